// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite fan-out: response codes, path state
// encodings and the address-region decode used by both paths.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_WAIT_B, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT_R, R_RESP} rd_state_t;

  // Addresses arrive zero-extended to 64 bits so one function serves any ADDR_WIDTH.
  function automatic logic [63:0] region_index(input logic [63:0] addr, input int region_bits);
    return addr >> region_bits;
  endfunction

  function automatic logic region_mapped(input logic [63:0] addr, input int region_bits,
                                         input int num_slaves);
    return region_index(addr, region_bits) < 64'(num_slaves);
  endfunction

endpackage

// File: rtl/axil_fanout_watchdog.sv
// Stall counter for one fan-out path; expire flags the last allowed cycle
// of an outstanding downstream transaction. TIMEOUT_CYCLES = 0 never expires.
module axil_fanout_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CNT_W-1:0] count;

  // Saturates at LIMIT so a handshake that beats the timeout leaves it armed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (TIMEOUT_CYCLES != 0) && enable && (count == LIMIT);

endmodule

// File: rtl/axil_bus_fanout.sv
// AXI4-Lite 1-to-N fan-out by power-of-two address regions. Independent read
// and write paths, one outstanding transaction each, DECERR/SLVERR generation.
module axil_bus_fanout #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int RESP_WIDTH     = 2,
  parameter int NUM_SLAVES     = 4,
  parameter int REGION_BITS    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             axi_aclk,
  input  logic                             axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]            s0_axi_awaddr,
  input  logic                             s0_axi_awvalid,
  output logic                             s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]            s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]          s0_axi_wstrb,
  input  logic                             s0_axi_wvalid,
  output logic                             s0_axi_wready,
  output logic [RESP_WIDTH-1:0]            s0_axi_bresp,
  output logic                             s0_axi_bvalid,
  input  logic                             s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]            s0_axi_araddr,
  input  logic                             s0_axi_arvalid,
  output logic                             s0_axi_arready,
  output logic [DATA_WIDTH-1:0]            s0_axi_rdata,
  output logic [RESP_WIDTH-1:0]            s0_axi_rresp,
  output logic                             s0_axi_rvalid,
  input  logic                             s0_axi_rready,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [NUM_SLAVES-1:0]            m_axi_awvalid,
  input  logic [NUM_SLAVES-1:0]            m_axi_awready,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0] m_axi_wdata,
  output logic [NUM_SLAVES*DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic [NUM_SLAVES-1:0]            m_axi_wvalid,
  input  logic [NUM_SLAVES-1:0]            m_axi_wready,
  input  logic [NUM_SLAVES*RESP_WIDTH-1:0] m_axi_bresp,
  input  logic [NUM_SLAVES-1:0]            m_axi_bvalid,
  output logic [NUM_SLAVES-1:0]            m_axi_bready,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [NUM_SLAVES-1:0]            m_axi_arvalid,
  input  logic [NUM_SLAVES-1:0]            m_axi_arready,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [NUM_SLAVES*RESP_WIDTH-1:0] m_axi_rresp,
  input  logic [NUM_SLAVES-1:0]            m_axi_rvalid,
  output logic [NUM_SLAVES-1:0]            m_axi_rready
);

  import axil_pkg::*;

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  wr_state_t             wr_state;
  logic                  aw_held, w_held, aw_take, w_take, aw_fire, w_fire, wr_expire;
  logic [ADDR_WIDTH-1:0] aw_addr_q, wr_addr_now;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic [IDX_W-1:0]      wr_idx, wr_idx_now;
  logic                  wr_mapped, wr_map_now;

  rd_state_t             rd_state;
  logic                  ar_take, rd_expire;
  logic [ADDR_WIDTH-1:0] ar_addr_q;
  logic [IDX_W-1:0]      rd_idx, rd_idx_now;
  logic                  rd_mapped, rd_map_now;

  // Payload registers are broadcast; only the selected port ever sees a valid.
  assign m_axi_awaddr = {NUM_SLAVES{aw_addr_q}};
  assign m_axi_wdata  = {NUM_SLAVES{w_data_q}};
  assign m_axi_wstrb  = {NUM_SLAVES{w_strb_q}};
  assign m_axi_araddr = {NUM_SLAVES{ar_addr_q}};

  assign aw_take = s0_axi_awready && s0_axi_awvalid;
  assign w_take  = s0_axi_wready && s0_axi_wvalid;
  assign ar_take = s0_axi_arready && s0_axi_arvalid;
  assign aw_fire = m_axi_awvalid[wr_idx] && m_axi_awready[wr_idx];
  assign w_fire  = m_axi_wvalid[wr_idx] && m_axi_wready[wr_idx];

  always_comb begin
    wr_addr_now = aw_take ? s0_axi_awaddr : aw_addr_q;
    wr_idx_now  = IDX_W'(region_index(64'(wr_addr_now), REGION_BITS));
    wr_map_now  = region_mapped(64'(wr_addr_now), REGION_BITS, NUM_SLAVES);
    rd_idx_now  = IDX_W'(region_index(64'(s0_axi_araddr), REGION_BITS));
    rd_map_now  = region_mapped(64'(s0_axi_araddr), REGION_BITS, NUM_SLAVES);
  end

  axil_fanout_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wr_watchdog (
    .clk    (axi_aclk),
    .rst_n  (axi_aresetn),
    .clear  ((wr_state == W_IDLE) || (wr_state == W_RESP)),
    .enable (wr_mapped && ((wr_state == W_ISSUE) || (wr_state == W_WAIT_B))),
    .expire (wr_expire)
  );

  axil_fanout_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd_watchdog (
    .clk    (axi_aclk),
    .rst_n  (axi_aresetn),
    .clear  ((rd_state == R_IDLE) || (rd_state == R_RESP)),
    .enable (rd_mapped && ((rd_state == R_ISSUE) || (rd_state == R_WAIT_R))),
    .expire (rd_expire)
  );

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_state       <= W_IDLE;
      s0_axi_awready <= 1'b0;
      s0_axi_wready  <= 1'b0;
      s0_axi_bvalid  <= 1'b0;
      s0_axi_bresp   <= '0;
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      aw_addr_q      <= '0;
      w_data_q       <= '0;
      w_strb_q       <= '0;
      wr_idx         <= '0;
      wr_mapped      <= 1'b0;
      m_axi_awvalid  <= '0;
      m_axi_wvalid   <= '0;
      m_axi_bready   <= '0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_take) begin
            aw_addr_q <= s0_axi_awaddr;
            aw_held   <= 1'b1;
          end
          if (w_take) begin
            w_data_q <= s0_axi_wdata;
            w_strb_q <= s0_axi_wstrb;
            w_held   <= 1'b1;
          end
          if ((aw_held || aw_take) && (w_held || w_take)) begin
            s0_axi_awready <= 1'b0;
            s0_axi_wready  <= 1'b0;
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            wr_idx         <= wr_idx_now;
            wr_mapped      <= wr_map_now;
            if (wr_map_now) begin
              m_axi_awvalid[wr_idx_now] <= 1'b1;
              m_axi_wvalid[wr_idx_now]  <= 1'b1;
            end
            wr_state <= W_ISSUE;
          end else begin
            s0_axi_awready <= !(aw_held || aw_take);
            s0_axi_wready  <= !(w_held || w_take);
          end
        end
        W_ISSUE: begin
          if (!wr_mapped) begin
            s0_axi_bresp  <= RESP_WIDTH'(RESP_DECERR);
            s0_axi_bvalid <= 1'b1;
            wr_state      <= W_RESP;
          end else if (aw_fire || w_fire) begin
            if (aw_fire) m_axi_awvalid[wr_idx] <= 1'b0;
            if (w_fire)  m_axi_wvalid[wr_idx]  <= 1'b0;
            if ((aw_fire || !m_axi_awvalid[wr_idx]) && (w_fire || !m_axi_wvalid[wr_idx])) begin
              m_axi_bready[wr_idx] <= 1'b1;
              wr_state             <= W_WAIT_B;
            end
          end else if (wr_expire) begin
            m_axi_awvalid <= '0;
            m_axi_wvalid  <= '0;
            s0_axi_bresp  <= RESP_WIDTH'(RESP_SLVERR);
            s0_axi_bvalid <= 1'b1;
            wr_state      <= W_RESP;
          end
        end
        W_WAIT_B: begin
          if (m_axi_bvalid[wr_idx]) begin
            s0_axi_bresp  <= m_axi_bresp[wr_idx*RESP_WIDTH +: RESP_WIDTH];
            m_axi_bready  <= '0;
            s0_axi_bvalid <= 1'b1;
            wr_state      <= W_RESP;
          end else if (wr_expire) begin
            s0_axi_bresp  <= RESP_WIDTH'(RESP_SLVERR);
            m_axi_bready  <= '0;
            s0_axi_bvalid <= 1'b1;
            wr_state      <= W_RESP;
          end
        end
        W_RESP: begin
          if (s0_axi_bready) begin
            s0_axi_bvalid  <= 1'b0;
            s0_axi_awready <= 1'b1;
            s0_axi_wready  <= 1'b1;
            wr_state       <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      rd_state       <= R_IDLE;
      s0_axi_arready <= 1'b0;
      s0_axi_rvalid  <= 1'b0;
      s0_axi_rresp   <= '0;
      s0_axi_rdata   <= '0;
      ar_addr_q      <= '0;
      rd_idx         <= '0;
      rd_mapped      <= 1'b0;
      m_axi_arvalid  <= '0;
      m_axi_rready   <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (ar_take) begin
            s0_axi_arready <= 1'b0;
            ar_addr_q      <= s0_axi_araddr;
            rd_idx         <= rd_idx_now;
            rd_mapped      <= rd_map_now;
            if (rd_map_now) m_axi_arvalid[rd_idx_now] <= 1'b1;
            rd_state <= R_ISSUE;
          end else begin
            s0_axi_arready <= 1'b1;
          end
        end
        R_ISSUE: begin
          if (!rd_mapped) begin
            s0_axi_rdata  <= '0;
            s0_axi_rresp  <= RESP_WIDTH'(RESP_DECERR);
            s0_axi_rvalid <= 1'b1;
            rd_state      <= R_RESP;
          end else if (m_axi_arready[rd_idx]) begin
            m_axi_arvalid        <= '0;
            m_axi_rready[rd_idx] <= 1'b1;
            rd_state             <= R_WAIT_R;
          end else if (rd_expire) begin
            m_axi_arvalid <= '0;
            s0_axi_rdata  <= '0;
            s0_axi_rresp  <= RESP_WIDTH'(RESP_SLVERR);
            s0_axi_rvalid <= 1'b1;
            rd_state      <= R_RESP;
          end
        end
        R_WAIT_R: begin
          if (m_axi_rvalid[rd_idx]) begin
            s0_axi_rdata  <= m_axi_rdata[rd_idx*DATA_WIDTH +: DATA_WIDTH];
            s0_axi_rresp  <= m_axi_rresp[rd_idx*RESP_WIDTH +: RESP_WIDTH];
            m_axi_rready  <= '0;
            s0_axi_rvalid <= 1'b1;
            rd_state      <= R_RESP;
          end else if (rd_expire) begin
            m_axi_rready  <= '0;
            s0_axi_rdata  <= '0;
            s0_axi_rresp  <= RESP_WIDTH'(RESP_SLVERR);
            s0_axi_rvalid <= 1'b1;
            rd_state      <= R_RESP;
          end
        end
        R_RESP: begin
          if (s0_axi_rready) begin
            s0_axi_rvalid  <= 1'b0;
            s0_axi_arready <= 1'b1;
            rd_state       <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_bus_fanout.sv
// Directed bench for axil_bus_fanout: four downstream slaves with constant
// ready/valid knobs, a handshake monitor, and hand-computed expectations.
module tb_axil_bus_fanout;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int RW = 2;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  logic [AW-1:0]    s0_axi_awaddr = '0;
  logic             s0_axi_awvalid = 1'b0;
  logic             s0_axi_awready;
  logic [DW-1:0]    s0_axi_wdata = '0;
  logic [SW-1:0]    s0_axi_wstrb = '0;
  logic             s0_axi_wvalid = 1'b0;
  logic             s0_axi_wready;
  logic [RW-1:0]    s0_axi_bresp;
  logic             s0_axi_bvalid;
  logic             s0_axi_bready = 1'b0;
  logic [AW-1:0]    s0_axi_araddr = '0;
  logic             s0_axi_arvalid = 1'b0;
  logic             s0_axi_arready;
  logic [DW-1:0]    s0_axi_rdata;
  logic [RW-1:0]    s0_axi_rresp;
  logic             s0_axi_rvalid;
  logic             s0_axi_rready = 1'b0;

  logic [NS*AW-1:0] m_axi_awaddr;
  logic [NS-1:0]    m_axi_awvalid;
  logic [NS-1:0]    m_axi_awready = '1;
  logic [NS*DW-1:0] m_axi_wdata;
  logic [NS*SW-1:0] m_axi_wstrb;
  logic [NS-1:0]    m_axi_wvalid;
  logic [NS-1:0]    m_axi_wready = '1;
  logic [NS*RW-1:0] m_axi_bresp = {2'b00, 2'b00, 2'b00, 2'b10};
  logic [NS-1:0]    m_axi_bvalid = '1;
  logic [NS-1:0]    m_axi_bready;
  logic [NS*AW-1:0] m_axi_araddr;
  logic [NS-1:0]    m_axi_arvalid;
  logic [NS-1:0]    m_axi_arready = '1;
  logic [NS*DW-1:0] m_axi_rdata = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'hCAFE_0000};
  logic [NS*RW-1:0] m_axi_rresp = {2'b00, 2'b00, 2'b00, 2'b00};
  logic [NS-1:0]    m_axi_rvalid = '1;
  logic [NS-1:0]    m_axi_rready;

  int total = 0;
  int bad = 0;

  int            aw_cnt [NS];
  int            w_cnt  [NS];
  int            ar_cnt [NS];
  logic [AW-1:0] awaddr_seen [NS];
  logic [DW-1:0] wdata_seen  [NS];
  logic [AW-1:0] araddr_seen [NS];
  logic [NS-1:0] act_seen = '0;

  axil_bus_fanout #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW),
    .NUM_SLAVES(NS), .REGION_BITS(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .axi_aclk(clk), .axi_aresetn(rstn),
    .s0_axi_awaddr(s0_axi_awaddr), .s0_axi_awvalid(s0_axi_awvalid), .s0_axi_awready(s0_axi_awready),
    .s0_axi_wdata(s0_axi_wdata), .s0_axi_wstrb(s0_axi_wstrb), .s0_axi_wvalid(s0_axi_wvalid),
    .s0_axi_wready(s0_axi_wready),
    .s0_axi_bresp(s0_axi_bresp), .s0_axi_bvalid(s0_axi_bvalid), .s0_axi_bready(s0_axi_bready),
    .s0_axi_araddr(s0_axi_araddr), .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arready(s0_axi_arready),
    .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp), .s0_axi_rvalid(s0_axi_rvalid),
    .s0_axi_rready(s0_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  // Handshakes are sampled at the rising edge, before the DUT's registers update.
  always @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < NS; i++) begin
        if (m_axi_awvalid[i] && m_axi_awready[i]) begin
          aw_cnt[i]++;
          awaddr_seen[i] = m_axi_awaddr[i*AW +: AW];
        end
        if (m_axi_wvalid[i] && m_axi_wready[i]) begin
          w_cnt[i]++;
          wdata_seen[i] = m_axi_wdata[i*DW +: DW];
        end
        if (m_axi_arvalid[i] && m_axi_arready[i]) begin
          ar_cnt[i]++;
          araddr_seen[i] = m_axi_araddr[i*AW +: AW];
        end
      end
      act_seen = act_seen | m_axi_awvalid | m_axi_wvalid | m_axi_arvalid | m_axi_bready | m_axi_rready;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    for (int i = 0; i < NS; i++) begin
      aw_cnt[i] = 0; w_cnt[i] = 0; ar_cnt[i] = 0;
      awaddr_seen[i] = '0; wdata_seen[i] = '0; araddr_seen[i] = '0;
    end
    act_seen = '0;
  endtask

  // lat = negedges from address acceptance until s0 bvalid is seen (bounded at 40).
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output logic [RW-1:0] resp, output int lat);
    s0_axi_awaddr = a; s0_axi_wdata = d; s0_axi_wstrb = '1;
    s0_axi_awvalid = 1'b1; s0_axi_wvalid = 1'b1; s0_axi_bready = 1'b1;
    @(negedge clk);
    s0_axi_awvalid = 1'b0; s0_axi_wvalid = 1'b0;
    lat = 1;
    while (!s0_axi_bvalid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    resp = s0_axi_bresp;
    @(negedge clk);
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                         output logic [RW-1:0] resp, output int lat);
    s0_axi_araddr = a; s0_axi_arvalid = 1'b1; s0_axi_rready = 1'b1;
    @(negedge clk);
    s0_axi_arvalid = 1'b0;
    lat = 1;
    while (!s0_axi_rvalid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    resp = s0_axi_rresp;
    d = s0_axi_rdata;
    @(negedge clk);
  endtask

  initial begin
    logic [RW-1:0] resp, resp2;
    logic [DW-1:0] data;
    int lat, held;

    clear_mon();
    repeat (3) @(negedge clk);
    check_val("rst_awready", s0_axi_awready, 0);
    check_val("rst_wready", s0_axi_wready, 0);
    check_val("rst_arready", s0_axi_arready, 0);
    check_val("rst_s0_valids", {s0_axi_bvalid, s0_axi_rvalid}, 0);
    check_val("rst_m_ctrl", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
    rstn = 1'b1;
    @(negedge clk);
    check_val("idle_awready", s0_axi_awready, 1);
    check_val("idle_wready", s0_axi_wready, 1);
    check_val("idle_arready", s0_axi_arready, 1);

    // Write 0x12 to 0x14 (slave 1), cycle-by-cycle.
    clear_mon();
    s0_axi_awaddr = 8'h14; s0_axi_wdata = 32'h12; s0_axi_wstrb = 4'hF;
    s0_axi_awvalid = 1'b1; s0_axi_wvalid = 1'b1; s0_axi_bready = 1'b1;
    @(negedge clk);
    s0_axi_awvalid = 1'b0; s0_axi_wvalid = 1'b0;
    check_val("w1_c1_awvalid", m_axi_awvalid, 4'b0010);
    check_val("w1_c1_wvalid", m_axi_wvalid, 4'b0010);
    check_val("w1_c1_awaddr", m_axi_awaddr[1*AW +: AW], 8'h14);
    check_val("w1_c1_wdata", m_axi_wdata[1*DW +: DW], 32'h12);
    check_val("w1_c1_awready", s0_axi_awready, 0);
    @(negedge clk);
    check_val("w1_c2_bready", m_axi_bready, 4'b0010);
    check_val("w1_c2_awvalid", m_axi_awvalid, 0);
    check_val("w1_c2_bvalid", s0_axi_bvalid, 0);
    @(negedge clk);
    check_val("w1_c3_bvalid", s0_axi_bvalid, 1);
    check_val("w1_c3_bresp", s0_axi_bresp, 2'b00);
    @(negedge clk);
    check_val("w1_c4_bvalid", s0_axi_bvalid, 0);
    check_val("w1_c4_awready", s0_axi_awready, 1);
    check_val("w1_act", act_seen, 4'b0010);
    check_val("w1_awcnt", aw_cnt[1], 1);

    // W two cycles ahead of AW, slave 3.
    clear_mon();
    s0_axi_wdata = 32'hA5A5_0003; s0_axi_wstrb = 4'h3; s0_axi_wvalid = 1'b1;
    @(negedge clk);
    s0_axi_wvalid = 1'b0;
    check_val("w2_wready_held", s0_axi_wready, 0);
    check_val("w2_awready_open", s0_axi_awready, 1);
    @(negedge clk);
    check_val("w2_no_issue", act_seen, 0);
    s0_axi_awaddr = 8'h3C; s0_axi_awvalid = 1'b1;
    @(negedge clk);
    s0_axi_awvalid = 1'b0;
    check_val("w2_awvalid", m_axi_awvalid, 4'b1000);
    check_val("w2_wstrb", m_axi_wstrb[3*SW +: SW], 4'h3);
    lat = 1;
    while (!s0_axi_bvalid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_val("w2_lat", lat, 3);
    check_val("w2_bresp", s0_axi_bresp, 2'b00);
    repeat (4) @(negedge clk);
    check_val("w2_awcnt", aw_cnt[3], 1);
    check_val("w2_wcnt", w_cnt[3], 1);
    check_val("w2_wdata", wdata_seen[3], 32'hA5A5_0003);
    check_val("w2_awaddr", awaddr_seen[3], 8'h3C);
    check_val("w2_act", act_seen, 4'b1000);

    // Unmapped write and read.
    clear_mon();
    do_write(8'hF0, 32'hDEAD, resp, lat);
    check_val("wdec_lat", lat, 2);
    check_val("wdec_bresp", resp, 2'b11);
    do_read(8'h50, data, resp, lat);
    check_val("rdec_lat", lat, 2);
    check_val("rdec_rresp", resp, 2'b11);
    check_val("rdec_rdata", data, 0);
    check_val("dec_act", act_seen, 0);

    // Mapped read from slave 1.
    clear_mon();
    do_read(8'h18, data, resp, lat);
    check_val("rd1_lat", lat, 3);
    check_val("rd1_rdata", data, 32'h1111_0001);
    check_val("rd1_araddr", araddr_seen[1], 8'h18);
    check_val("rd1_act", act_seen, 4'b0010);

    // Slave 2 never accepts AR: watchdog after 8 issue cycles.
    clear_mon();
    m_axi_arready[2] = 1'b0;
    do_read(8'h24, data, resp, lat);
    check_val("to_lat", lat, 9);
    check_val("to_rresp", resp, 2'b10);
    check_val("to_rdata", data, 0);
    check_val("to_arvalid_drop", m_axi_arvalid, 0);
    check_val("to_rready", m_axi_rready, 0);
    check_val("to_arcnt", ar_cnt[2], 0);
    check_val("to_act", act_seen, 4'b0100);
    m_axi_arready[2] = 1'b1;

    // Concurrent write and read on slave 0 with delayed s0 acceptance.
    clear_mon();
    s0_axi_awaddr = 8'h04; s0_axi_wdata = 32'h0BAD_F00D; s0_axi_wstrb = 4'hF;
    s0_axi_araddr = 8'h08;
    s0_axi_bready = 1'b0; s0_axi_rready = 1'b0;
    s0_axi_awvalid = 1'b1; s0_axi_wvalid = 1'b1; s0_axi_arvalid = 1'b1;
    @(negedge clk);
    s0_axi_awvalid = 1'b0; s0_axi_wvalid = 1'b0; s0_axi_arvalid = 1'b0;
    lat = 1;
    while (!(s0_axi_bvalid && s0_axi_rvalid) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_val("cc_lat", lat, 3);
    held = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (s0_axi_bvalid && s0_axi_rvalid && s0_axi_bresp == 2'b10 && s0_axi_rdata == 32'hCAFE_0000)
        held++;
    end
    check_val("cc_held", held, 5);
    check_val("cc_bresp", s0_axi_bresp, 2'b10);
    check_val("cc_rdata", s0_axi_rdata, 32'hCAFE_0000);
    s0_axi_bready = 1'b1; s0_axi_rready = 1'b1;
    @(negedge clk);
    check_val("cc_done", {s0_axi_bvalid, s0_axi_rvalid}, 0);
    check_val("cc_counts", {aw_cnt[0][7:0], w_cnt[0][7:0], ar_cnt[0][7:0]}, 24'h010101);
    check_val("cc_act", act_seen, 4'b0001);

    // Reset while waiting for B on slave 1.
    clear_mon();
    m_axi_bvalid[1] = 1'b0;
    s0_axi_awaddr = 8'h10; s0_axi_wdata = 32'h77; s0_axi_bready = 1'b1;
    s0_axi_awvalid = 1'b1; s0_axi_wvalid = 1'b1;
    @(negedge clk);
    s0_axi_awvalid = 1'b0; s0_axi_wvalid = 1'b0;
    @(negedge clk);
    check_val("rs_wait_bready", m_axi_bready, 4'b0010);
    #2 rstn = 1'b0;
    #1;
    check_val("rs_async_m", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 0);
    check_val("rs_async_s0", {s0_axi_bvalid, s0_axi_awready}, 0);
    @(negedge clk);
    rstn = 1'b1;
    m_axi_bvalid[1] = 1'b1;
    @(negedge clk);
    check_val("rs_no_stale_b", s0_axi_bvalid, 0);
    check_val("rs_idle_bready", m_axi_bready, 0);
    do_write(8'h1C, 32'h55, resp2, lat);
    check_val("rs_next_lat", lat, 3);
    check_val("rs_next_bresp", resp2, 2'b00);
    check_val("rs_next_wdata", wdata_seen[1], 32'h55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axil_bus_fanout.md
# axil_bus_fanout

Parametrised AXI4-Lite 1-to-N fan-out: one upstream slave port (s0) decoded onto NUM_SLAVES downstream master ports (m) by fixed power-of-two address regions. Read and write paths are independent FSMs, each with one outstanding transaction. Unmapped addresses get DECERR, and stalled downstream slaves get SLVERR via a watchdog. It replaces the fixed two-target bus at the top of the register-access fabric.

## Interface
- DATA_WIDTH, 32, data width; multiple of 8
- ADDR_WIDTH, 8, address width
- RESP_WIDTH, 2, response width
- NUM_SLAVES, 4, downstream ports, 1..16
- REGION_BITS, 4, log2 bytes per region; slave index = addr >> REGION_BITS
- TIMEOUT_CYCLES, 64, watchdog limit; 0 disables
- axi_aclk  in  1  sole clock, all logic rising-edge
- axi_aresetn  in  1  reset, asynchronous, active-low
- s0_axi_aw{addr,valid,ready}, s0_axi_w{data,strb,valid,ready}, s0_axi_b{resp,valid,ready}, s0_axi_ar{addr,valid,ready}, s0_axi_r{data,resp,valid,ready}  standard AXI-Lite slave directions  widths ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8 / RESP_WIDTH / 1
- m_axi_* (same channel set, master directions)  packed NUM_SLAVES x per-channel width; slave i occupies slice [i*W +: W]

## Operation
- Decode: idx = addr >> REGION_BITS. idx >= NUM_SLAVES is unmapped. The address is forwarded unmodified.
- Write FSM, W_IDLE -> W_ISSUE -> W_WAIT_B -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1 until AW is captured and wready=1 until W is captured; AW and W may arrive in either order or together. Leave when both are held.
  - Mapped: W_ISSUE drives m awvalid[idx] and wvalid[idx] from registers. Each is dropped independently at its own handshake. Go to W_WAIT_B when both are done.
  - W_WAIT_B: bready[idx]=1. On bvalid[idx], capture bresp and go to W_RESP.
  - Unmapped: skip to W_RESP with bresp=2'b11.
  - W_RESP: s0 bvalid=1 until bready, then W_IDLE.
- Read FSM, R_IDLE -> R_ISSUE -> R_WAIT_R -> R_RESP -> R_IDLE.
  - R_IDLE: arready=1.
  - Mapped: R_ISSUE drives arvalid[idx] until handshake. R_WAIT_R holds rready[idx]=1 and captures rdata/rresp.
  - Unmapped: rdata=0, rresp=2'b11.
  - R_RESP: s0 rvalid until rready.
- Watchdog, per FSM: counts cycles spent in ISSUE+WAIT. On reaching TIMEOUT_CYCLES, all m valid/ready for that path are deasserted and the path goes to RESP with resp=2'b10 (rdata=0).
  - A late downstream response is dropped: the matching ready stays 0, because the next transaction re-arms the port only after its own ISSUE.
- m ports other than idx have every valid/ready held at 0.

## Timing
- Reset values (asynchronous): all s0 ready/valid 0, all m valid/ready 0, all data/addr/resp registers 0, FSMs in IDLE, counters 0. The IDLE ready signals assert on the first clock after reset release.
- Write, zero-wait downstream: AW+W accepted at cycle 0; m valid at cycle 1 with handshake; bvalid seen at cycle 2; s0 bvalid at cycle 3. Four cycles minimum, three for unmapped.
- Read, zero-wait downstream: same shape, ar at cycle 0 to s0 rvalid at cycle 3.
- All outputs are registered; no combinational path from s0 to m.
- Read and write to the same slave at the same time are allowed; the paths never arbitrate.
- Watchdog counter width is $clog2(TIMEOUT_CYCLES+1). Timeout fires in the cycle the count equals TIMEOUT_CYCLES-1 with no handshake; a handshake in that same cycle wins.
- Reset mid-transaction aborts immediately. The in-flight response is never emitted.

## Structure
- axil_pkg: resp constants (OKAY=0, SLVERR=2, DECERR=3), write/read state enums.
- Sub-module axil_fanout_watchdog: counter with clear/enable inputs and an expire output, instanced once per path.
- Decode is a shared function in axil_pkg.

## Test plan
- Write 0x12 to addr 0x14 (slave 1), all m ready=1 -> m1 awaddr=0x14, wdata=0x12, s0 bresp=0 at cycle 3; other m valids stay 0.
- W presented 2 cycles before AW to slave 3 -> single m3 transaction, bresp=0, no duplicate.
- Read addr 0x50 with NUM_SLAVES=4 -> no m arvalid, rresp=3, rdata=0, three cycles.
- Slave 2 holds arready=0, TIMEOUT_CYCLES=8 -> rresp=2 after 8 issue cycles; arvalid[2] drops.
- Concurrent write to slave 0 and read from slave 0, s0 bready/rready delayed 5 cycles -> both complete; b/rvalid held stable until accepted.
- Assert axi_aresetn low during W_WAIT_B -> all valids 0 asynchronously; the next write completes normally.
